// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai_filt_pkg.sv
// Shared types and parameter limits for the filtered OAI cell.
package gf180mcu_fd_sc_mcu7t5v0__oai_filt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } filt_state_t;

    localparam int GROUPS_MIN = 1;
    localparam int GROUPS_MAX = 8;
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 8;
    localparam int FILT_MIN   = 1;
    localparam int FILT_MAX   = 255;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai_filt_comb.sv
// Combinational OR-AND-invert reduction: raw = ~&(|group_g) over all groups.
module gf180mcu_fd_sc_mcu7t5v0__oai_filt_comb
    import gf180mcu_fd_sc_mcu7t5v0__oai_filt_pkg::*;
#(
    parameter int GROUPS = 3,
    parameter int WIDTH  = 2
) (
    input  logic [GROUPS*WIDTH-1:0] a,
    output logic                    raw
);

    if (GROUPS < GROUPS_MIN || GROUPS > GROUPS_MAX) begin : g_bad_groups
        $error("GROUPS out of range 1..8");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("WIDTH out of range 1..8");
    end

    logic [GROUPS-1:0] grp_or;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        assign grp_or[g] = |a[g*WIDTH +: WIDTH];
    end

    assign raw = ~&grp_or;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai_filt.sv
// Registered OAI with optional persistence filter: a new result must hold FILT enabled cycles before ZN follows.
module gf180mcu_fd_sc_mcu7t5v0__oai_filt
    import gf180mcu_fd_sc_mcu7t5v0__oai_filt_pkg::*;
#(
    parameter int GROUPS = 3,
    parameter int WIDTH  = 2,
    parameter int FILT   = 4
) (
    input  logic                    CLK,
    input  logic                    RN,
    input  logic [GROUPS*WIDTH-1:0] A,
    input  logic                    E,
    input  logic                    MODE,
    output logic                    ZN,
    output logic                    CHG,
    output logic                    BUSY
);

    if (FILT < FILT_MIN || FILT > FILT_MAX) begin : g_bad_filt
        $error("FILT out of range 1..255");
    end

    localparam int             CW       = $clog2(FILT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

    logic [GROUPS*WIDTH-1:0] a_q;
    logic                    raw;
    logic                    zn;
    logic                    chg;
    logic                    mode_q;
    logic [CW-1:0]           cnt;
    filt_state_t             state;

    gf180mcu_fd_sc_mcu7t5v0__oai_filt_comb #(
        .GROUPS(GROUPS),
        .WIDTH (WIDTH)
    ) u_comb (
        .a  (a_q),
        .raw(raw)
    );

    // mode_q remembers the mode of the previous enabled edge so a switch can
    // abandon any pending qualification without touching ZN.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            a_q    <= '0;
            zn     <= 1'b1;
            chg    <= 1'b0;
            mode_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
        end else if (!E) begin
            chg <= 1'b0;
        end else begin
            a_q    <= A;
            mode_q <= MODE;
            chg    <= 1'b0;
            if (MODE != mode_q) begin
                cnt   <= '0;
                state <= IDLE;
            end else if (!MODE || FILT == 1) begin
                zn    <= raw;
                chg   <= raw ^ zn;
                cnt   <= '0;
                state <= IDLE;
            end else if (raw == zn) begin
                cnt   <= '0;
                state <= IDLE;
            end else if (state == IDLE) begin
                cnt   <= CW'(1);
                state <= PEND;
            end else if (cnt == CNT_LAST) begin
                zn    <= raw;
                chg   <= 1'b1;
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // CHG is masked by E so it reads 0 for the whole of any disabled cycle.
    assign ZN   = zn;
    assign CHG  = chg & E;
    assign BUSY = (state == PEND);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai_filt.sv
// Scenario bench for the filtered OAI cell against a queue-based reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai_filt;

    localparam int GROUPS = 3;
    localparam int WIDTH  = 2;
    localparam int FILT   = 4;
    localparam int AW     = GROUPS * WIDTH;

    logic          CLK  = 1'b0;
    logic          RN   = 1'b0;
    logic          E    = 1'b0;
    logic          MODE = 1'b0;
    logic [AW-1:0] A    = '0;
    logic          ZN;
    logic          CHG;
    logic          BUSY;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a_q image, ZN, CHG, last-seen mode and the run of
    // differing results collected so far.
    logic [AW-1:0] m_aq;
    logic          m_zn;
    logic          m_chg;
    logic          m_mode;
    bit            hist[$];

    gf180mcu_fd_sc_mcu7t5v0__oai_filt #(
        .GROUPS(GROUPS),
        .WIDTH (WIDTH),
        .FILT  (FILT)
    ) dut (
        .CLK (CLK),
        .RN  (RN),
        .A   (A),
        .E   (E),
        .MODE(MODE),
        .ZN  (ZN),
        .CHG (CHG),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic oai_ref(input logic [AW-1:0] v);
        int groups_hit = 0;
        for (int g = 0; g < GROUPS; g++) begin
            bit any = 1'b0;
            for (int w = 0; w < WIDTH; w++)
                if (v[g*WIDTH + w]) any = 1'b1;
            if (any) groups_hit++;
        end
        return (groups_hit == GROUPS) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [2:0] exp_out();
        return {m_zn, m_chg & E, hist.size() != 0};
    endfunction

    task automatic model_reset();
        m_aq   = '0;
        m_zn   = 1'b1;
        m_chg  = 1'b0;
        m_mode = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        logic r;
        logic prev;
        if (!RN) return;
        if (!E) begin
            m_chg = 1'b0;
            return;
        end
        r    = oai_ref(m_aq);
        prev = m_zn;
        if (MODE != m_mode) begin
            hist.delete();
        end else if (!MODE) begin
            m_zn = r;
            hist.delete();
        end else if (r == m_zn) begin
            hist.delete();
        end else begin
            hist.push_back(r);
            if (hist.size() == FILT) begin
                m_zn = r;
                hist.delete();
            end
        end
        m_chg  = (m_zn != prev);
        m_mode = MODE;
        m_aq   = A;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RN = 1'b0; A = 6'b111111; MODE = 1'b1; E = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (ZN !== 1'b1) begin tests_failed++; $display("FAIL reset_zn: got %b want 1", ZN); end
        tests_run++;
        if (CHG !== 1'b0) begin tests_failed++; $display("FAIL reset_chg: got %b want 0", CHG); end
        tests_run++;
        if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        RN = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            tests_run++;
            if ({ZN, CHG, BUSY} !== exp_out()) begin
                tests_failed++;
                $display("FAIL release_model edge %0d: got %b want %b", i, {ZN, CHG, BUSY}, exp_out());
            end
            if (i == 4) begin
                tests_run++;
                if ({ZN, BUSY} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL release_edge4 zn/busy: got %b want 11", {ZN, BUSY});
                end
            end
            if (i == 5) begin
                tests_run++;
                if ({ZN, CHG} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL release_edge5 zn/chg: got %b want 01", {ZN, CHG});
                end
            end
        end
    endtask

    task automatic test_glitch();
        int busy_cycles = 0;
        int chg_cycles  = 0;
        int zn_ones     = 0;
        A = 6'b111100;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) A = 6'b111111;
            tick();
            busy_cycles += int'(BUSY);
            chg_cycles  += int'(CHG);
            zn_ones     += int'(ZN);
            tests_run++;
            if ({ZN, CHG, BUSY} !== exp_out()) begin
                tests_failed++;
                $display("FAIL glitch_model cycle %0d: got %b want %b", i, {ZN, CHG, BUSY}, exp_out());
            end
        end
        tests_run++;
        if (busy_cycles != 3 || chg_cycles != 0 || zn_ones != 0) begin
            tests_failed++;
            $display("FAIL glitch_summary: busy=%0d chg=%0d zn_high=%0d want 3/0/0",
                     busy_cycles, chg_cycles, zn_ones);
        end
    endtask

    task automatic test_bypass();
        logic [AW-1:0] a_prev;
        int chg_cycles = 0;
        MODE = 1'b0;
        tick();
        a_prev = A;
        for (int i = 0; i < 10; i++) begin
            A = (i % 2 == 1) ? 6'b000101 : 6'b010101;
            tick();
            chg_cycles += int'(CHG);
            tests_run++;
            if ({ZN, CHG, BUSY} !== exp_out()) begin
                tests_failed++;
                $display("FAIL bypass_model step %0d: got %b want %b", i, {ZN, CHG, BUSY}, exp_out());
            end
            if (i >= 1) begin
                tests_run++;
                if (ZN !== (a_prev == 6'b000101)) begin
                    tests_failed++;
                    $display("FAIL bypass_latency step %0d: got %b want %b", i, ZN, a_prev == 6'b000101);
                end
            end
            a_prev = A;
        end
        tests_run++;
        if (chg_cycles != 8) begin
            tests_failed++;
            $display("FAIL bypass_chg_count: got %0d want 8", chg_cycles);
        end
    endtask

    task automatic test_enable_hold();
        MODE = 1'b1;
        A    = 6'b000101;
        repeat (7) tick();
        tests_run++;
        if (ZN !== 1'b1) begin tests_failed++; $display("FAIL hold_setup_zn: got %b want 1", ZN); end
        A = 6'b111111;
        repeat (3) tick();
        tests_run++;
        if ({ZN, BUSY} !== 2'b11) begin
            tests_failed++;
            $display("FAIL hold_pend: got %b want 11", {ZN, BUSY});
        end
        E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({ZN, CHG, BUSY} !== 3'b101) begin
                tests_failed++;
                $display("FAIL hold_frozen cycle %0d: got %b want 101", i, {ZN, CHG, BUSY});
            end
        end
        E = 1'b1;
        tick();
        tests_run++;
        if ({ZN, CHG, BUSY} !== 3'b101 || exp_out() !== 3'b101) begin
            tests_failed++;
            $display("FAIL hold_resume1: got %b want 101 (model %b)", {ZN, CHG, BUSY}, exp_out());
        end
        tick();
        tests_run++;
        if ({ZN, CHG, BUSY} !== 3'b010 || exp_out() !== 3'b010) begin
            tests_failed++;
            $display("FAIL hold_resume2: got %b want 010 (model %b)", {ZN, CHG, BUSY}, exp_out());
        end
    endtask

    task automatic test_async_reset();
        A = 6'b000000;
        repeat (3) tick();
        tests_run++;
        if ({ZN, BUSY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL async_setup: got %b want 01", {ZN, BUSY});
        end
        #2;
        RN = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({ZN, CHG, BUSY} !== 3'b100) begin
            tests_failed++;
            $display("FAIL async_assert: got %b want 100", {ZN, CHG, BUSY});
        end
        A = 6'b111111;
        #1;
        RN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests_run++;
            if ({ZN, CHG, BUSY} !== exp_out()) begin
                tests_failed++;
                $display("FAIL async_recover edge %0d: got %b want %b", i, {ZN, CHG, BUSY}, exp_out());
            end
            if (i == 4 || i == 5) begin
                tests_run++;
                if (ZN !== (i == 4)) begin
                    tests_failed++;
                    $display("FAIL async_count_cleared edge %0d: got %b want %b", i, ZN, i == 4);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        A = 6'b000000;
        repeat (3) tick();
        tests_run++;
        if ({ZN, BUSY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL mode_setup: got %b want 01", {ZN, BUSY});
        end
        MODE = 1'b0;
        tick();
        tests_run++;
        if ({ZN, CHG, BUSY} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mode_switch_edge: got %b want 000", {ZN, CHG, BUSY});
        end
        tick();
        tests_run++;
        if ({ZN, CHG, BUSY} !== 3'b110 || exp_out() !== 3'b110) begin
            tests_failed++;
            $display("FAIL mode_next_edge: got %b want 110 (model %b)", {ZN, CHG, BUSY}, exp_out());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) A = AW'($urandom);
            E = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) MODE = ~MODE;
            if ($urandom_range(0, 149) == 0) begin
                RN = 1'b0;
                model_reset();
                #1;
                tests_run++;
                if ({ZN, CHG, BUSY} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL random_reset step %0d: got %b want 100", i, {ZN, CHG, BUSY});
                end
                RN = 1'b1;
            end
            tick();
            tests_run++;
            if ({ZN, CHG, BUSY} !== exp_out()) begin
                tests_failed++;
                $display("FAIL random_model step %0d: got %b want %b", i, {ZN, CHG, BUSY}, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bypass();
        test_enable_hold();
        test_async_reset();
        test_mode_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
